// File: rtl/i2c_slave_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slave_pkg
// Shared definitions for the I2C target controller: FSM state encoding,
// width of the pad stability-filter counter, and the ACK/NACK bit levels.
// ---------------------------------------------------------------------------
package i2c_slave_pkg;

  // Wide enough for FILT_LEN values up to 15.
  localparam int FILT_CNT_W = 4;

  // Level on SDA during the 9th (acknowledge) bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_slave_filter.sv
// ---------------------------------------------------------------------------
// i2c_slave_filter
// Two-flop synchronizer followed by a stability filter for one I2C pad.
// A new synchronized level is accepted only after it has been stable for
// FILT_LEN consecutive cycles; rise/fall pulse for one cycle in the same
// cycle the filtered level changes.
//
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset (bus idles high)
//   pad    - raw pad level
//   level  - filtered level
//   rise   - one-cycle pulse, filtered level went 0 -> 1
//   fall   - one-cycle pulse, filtered level went 1 -> 0
// ---------------------------------------------------------------------------
module i2c_slave_filter
  import i2c_slave_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic                  sync1_reg;
  logic                  sync2_reg;
  logic [FILT_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level     <= 1'b1;
      cnt_reg   <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync1_reg <= pad;
      sync2_reg <= sync1_reg;
      rise      <= 1'b0;
      fall      <= 1'b0;
      if (sync2_reg == level) begin
        // Any return to the accepted level restarts the stability window.
        cnt_reg <= '0;
      end else if (cnt_reg == FILT_CNT_W'(FILT_LEN - 1)) begin
        level   <= sync2_reg;
        cnt_reg <= '0;
        rise    <= sync2_reg;
        fall    <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_slave_ctrl
// I2C target: oversamples SCL/SDA, detects START/STOP, matches a 7-bit
// address, ACKs, and moves bytes between the bus and a local byte stream.
// SCL is never driven (no clock stretching).
//
// Ports:
//   wb_clk_i      - system clock
//   wb_rst_i      - synchronous active-low reset
//   scl_pad_i     - SCL pad level
//   sda_pad_i     - SDA pad level
//   scl_pad_o     - constant 0
//   scl_padoen_o  - constant 1 (SCL never enabled)
//   sda_pad_o     - constant 0
//   sda_padoen_o  - active-low SDA enable (0 pulls SDA low)
//   rx_data_o     - last byte written by the master
//   rx_valid_o    - one-cycle pulse when rx_data_o updates and local is ready
//   rx_ready_i    - local side can accept data (0 => data byte is NACKed)
//   tx_data_i     - next byte to return on a read
//   tx_req_o      - one-cycle pulse requesting the next tx_data_i
//   busy_o        - 1 from START to STOP
//   stop_o        - one-cycle pulse on STOP
// ---------------------------------------------------------------------------
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       busy_o,
  output logic       stop_o
);

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] pads;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] fall;

  assign pads = {sda_pad_i, scl_pad_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    i2c_slave_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_i),
      .pad   (pads[gi]),
      .level (lvl[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi])
    );
  end

  logic scl_lvl;
  logic sda_lvl;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_lvl  = lvl[0];
  assign sda_lvl  = lvl[1];
  assign scl_rise = rise[0];
  assign scl_fall = fall[0];

  // An SDA edge coincident with an SCL edge is ordinary data movement.
  assign start_det = fall[1] & scl_lvl & ~(scl_rise | scl_fall);
  assign stop_det  = rise[1] & scl_lvl & ~(scl_rise | scl_fall);

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;

  i2c_slv_state_t state_reg;
  logic [3:0]     bit_cnt_reg;
  logic [7:0]     shift_reg;
  logic           rw_reg;     // 1 = read transaction
  logic           nack_reg;   // answer NACK in the coming acknowledge slot
  logic           phase_reg;  // ACK slot driven (xx_ACK) / master ACK seen (RD_ACK)

  logic [7:0] byte_in;
  logic       byte_done;

  assign byte_in   = {shift_reg[6:0], sda_lvl};
  assign byte_done = (bit_cnt_reg == 4'd7);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rw_reg       <= 1'b0;
      nack_reg     <= 1'b0;
      phase_reg    <= 1'b0;
      sda_padoen_o <= 1'b1;
      rx_data_o    <= 8'h00;
      rx_valid_o   <= 1'b0;
      tx_req_o     <= 1'b0;
      busy_o       <= 1'b0;
      stop_o       <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      stop_o     <= 1'b0;

      if (stop_det) begin
        busy_o       <= 1'b0;
        stop_o       <= 1'b1;
        sda_padoen_o <= 1'b1;
        bit_cnt_reg  <= '0;
        phase_reg    <= 1'b0;
        state_reg    <= IDLE;
      end else if (start_det) begin
        busy_o       <= 1'b1;
        sda_padoen_o <= 1'b1;
        bit_cnt_reg  <= '0;
        phase_reg    <= 1'b0;
        state_reg    <= ADDR;
      end else begin
        unique case (state_reg)
          ADDR: begin
            if (scl_rise) begin
              shift_reg <= byte_in;
              if (byte_done) begin
                bit_cnt_reg <= '0;
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  rw_reg    <= byte_in[0];
                  tx_req_o  <= byte_in[0];
                  nack_reg  <= 1'b0;
                  phase_reg <= 1'b0;
                  state_reg <= ADDR_ACK;
                end else begin
                  state_reg <= WAIT_STOP;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end

          // First SCL fall opens the acknowledge slot, second one closes it
          // and hands SDA to the next data phase.
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!phase_reg) begin
                phase_reg    <= 1'b1;
                sda_padoen_o <= nack_reg ? NACK : ACK;
              end else begin
                phase_reg   <= 1'b0;
                bit_cnt_reg <= '0;
                if (rw_reg) begin
                  shift_reg    <= tx_data_i;
                  sda_padoen_o <= tx_data_i[7];
                  state_reg    <= RD_DATA;
                end else begin
                  sda_padoen_o <= 1'b1;
                  state_reg    <= WR_DATA;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift_reg <= byte_in;
              if (byte_done) begin
                bit_cnt_reg <= '0;
                rx_data_o   <= byte_in;
                rx_valid_o  <= rx_ready_i;
                nack_reg    <= ~rx_ready_i;
                phase_reg   <= 1'b0;
                state_reg   <= WR_ACK;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end

          // The MSB went out when the phase was entered; each fall here
          // shifts out the next bit, the eighth fall frees SDA for the master.
          RD_DATA: begin
            if (scl_fall) begin
              if (byte_done) begin
                sda_padoen_o <= 1'b1;
                bit_cnt_reg  <= '0;
                phase_reg    <= 1'b0;
                state_reg    <= RD_ACK;
              end else begin
                sda_padoen_o <= shift_reg[6];
                shift_reg    <= {shift_reg[6:0], 1'b0};
                bit_cnt_reg  <= bit_cnt_reg + 4'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == ACK) begin
                tx_req_o  <= 1'b1;
                phase_reg <= 1'b1;
              end else begin
                state_reg <= WAIT_STOP;
              end
            end else if (scl_fall && phase_reg) begin
              phase_reg    <= 1'b0;
              bit_cnt_reg  <= '0;
              shift_reg    <= tx_data_i;
              sda_padoen_o <= tx_data_i[7];
              state_reg    <= RD_DATA;
            end
          end

          default: begin
            // IDLE and WAIT_STOP keep SDA released until START/STOP.
            sda_padoen_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
